// File: rtl/uart_tx_fifo_if.sv
// Host write port and transmitter launch port of the UART TX byte buffer.
// The slave modport is the buffer; the master modport is the host/transmitter side.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              flush;
    logic [7:0]        tx_data;
    logic              start_tx;
    logic              tx_done;
    logic              cts_n;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;
    logic              overflow;

    modport master (
        output wr_valid, wr_data, flush, tx_done, cts_n,
        input  wr_ready, tx_data, start_tx, level, empty, full, overflow
    );

    modport slave (
        input  wr_valid, wr_data, flush, tx_done, cts_n,
        output wr_ready, tx_data, start_tx, level, empty, full, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter, one start_tx pulse per byte, next byte on tx_done.
// Define UART_TX_CTS_GATE_EN to gate launches on a synchronized active-low cts_n.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] LVL_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    logic [7:0]      mem_q [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      tx_data_q;
    logic            start_tx_q;
    state_t          state_q;

    logic empty_s, full_s, wr_ready_s, push_s, launch_ok_s, launch_s, done_s;

`ifdef UART_TX_CTS_GATE_EN
    logic cts_meta_q, cts_sync_q;

    // Two-flop synchronizer; idles deasserted so nothing launches before the far end is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= bus.cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign launch_ok_s = !empty_s && !cts_sync_q;
`else
    logic unused_cts_s;
    assign unused_cts_s = bus.cts_n;
    assign launch_ok_s  = !empty_s;
`endif

    // Status, handshake and launch decision; a flush suppresses any launch from the cleared queue.
    always_comb begin
        empty_s    = (level_q == LVL_ZERO);
        full_s     = (level_q == LVL_FULL);
        wr_ready_s = !full_s && !bus.flush;
        push_s     = bus.wr_valid && wr_ready_s;
        done_s     = bus.tx_done && !start_tx_q;
        launch_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch_ok_s && !bus.flush) launch_s = 1'b1;
                else                           launch_s = 1'b0;
            end
            WAIT_DONE: begin
                if (done_s && launch_ok_s && !bus.flush) launch_s = 1'b1;
                else                                     launch_s = 1'b0;
            end
            default: launch_s = 1'b0;
        endcase
    end

    // Next-state of pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            rd_ptr_d   = wr_ptr_q;
            level_d    = LVL_ZERO;
            overflow_d = 1'b0;
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
            else        wr_ptr_d = wr_ptr_q;
            if (launch_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
            else          rd_ptr_d = rd_ptr_q;
            if (push_s && !launch_s)      level_d = level_q + PTR_ONE;
            else if (!push_s && launch_s) level_d = level_q - PTR_ONE;
            else                          level_d = level_q;
            if (bus.wr_valid && full_s) overflow_d = 1'b1;
            else                        overflow_d = overflow_q;
        end
    end

    // Pointer, occupancy and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= LVL_ZERO;
            rd_ptr_q   <= LVL_ZERO;
            level_q    <= LVL_ZERO;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
    end

    // Launch FSM; a byte already in flight is never disturbed by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            start_tx_q <= 1'b0;
        end else begin
            start_tx_q <= launch_s;
            if (launch_s) begin
                tx_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                state_q   <= WAIT_DONE;
            end else if (state_q == WAIT_DONE && done_s) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign bus.wr_ready = wr_ready_s;
    assign bus.tx_data  = tx_data_q;
    assign bus.start_tx = start_tx_q;
    assign bus.level    = level_q;
    assign bus.empty    = empty_s;
    assign bus.full     = full_s;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16); inputs change 1ns after rising edges.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    uart_tx_fifo_if #(.DEPTH(16)) bus();
    uart_tx_fifo #(.DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        bus.tx_done = 1'b0;
        bus.cts_n = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        write_byte(8'hC3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%0h exp=00", bus.tx_data); end
        checks++; if (bus.start_tx !== 1'b0) begin failures++; $display("FAIL rst_start got=%0b exp=0", bus.start_tx); end
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", bus.level); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL rst_empty_full got=%0b%0b exp=10", bus.empty, bus.full); end
        checks++; if (bus.overflow !== 1'b0 || bus.wr_ready !== 1'b1) begin failures++; $display("FAIL rst_ovf_rdy got=%0b%0b exp=01", bus.overflow, bus.wr_ready); end
        pulse_done();
        checks++; if (bus.start_tx !== 1'b0 || bus.level !== 5'd0) begin failures++; $display("FAIL rst_late_done start=%0b level=%0d exp 0/0", bus.start_tx, bus.level); end
    endtask

    task automatic test_single();
        int extra;
        bit held;
        do_reset();
        write_byte(8'hA5);
        checks++; if (bus.start_tx !== 1'b0 || bus.level !== 5'd1) begin failures++; $display("FAIL single_after_E start=%0b level=%0d exp 0/1", bus.start_tx, bus.level); end
        tick();
        checks++; if (bus.start_tx !== 1'b1 || bus.tx_data !== 8'hA5) begin failures++; $display("FAIL single_launch start=%0b data=%0h exp 1/a5", bus.start_tx, bus.tx_data); end
        checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL single_pop_level got=%0d exp=0", bus.level); end
        extra = 0;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.start_tx) extra++;
            if (bus.tx_data !== 8'hA5) held = 1'b0;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL single_no_restart got=%0d pulses exp=0", extra); end
        checks++; if (!held || bus.level !== 5'd0) begin failures++; $display("FAIL single_hold held=%0b level=%0d exp 1/0", held, bus.level); end
        pulse_done();
    endtask

    task automatic test_full_overflow();
        do_reset();
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        checks++; if (bus.level !== 5'd16 || bus.full !== 1'b1 || bus.wr_ready !== 1'b0) begin failures++; $display("FAIL full_state level=%0d full=%0b rdy=%0b exp 16/1/0", bus.level, bus.full, bus.wr_ready); end
        checks++; if (bus.overflow !== 1'b0 || bus.tx_data !== 8'h00) begin failures++; $display("FAIL full_first ovf=%0b data=%0h exp 0/00", bus.overflow, bus.tx_data); end
        write_byte(8'h99);
        checks++; if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin failures++; $display("FAIL overflow ovf=%0b level=%0d exp 1/16", bus.overflow, bus.level); end
        for (int i = 0; i < 17; i++) begin
            pulse_done();
            if (i < 16) begin
                checks++; if (bus.start_tx !== 1'b1 || bus.tx_data !== 8'(i + 1)) begin failures++; $display("FAIL drain_byte%0d start=%0b data=%0h exp 1/%0h", i, bus.start_tx, bus.tx_data, 8'(i + 1)); end
                checks++; if (bus.level !== 5'(15 - i)) begin failures++; $display("FAIL drain_level%0d got=%0d exp=%0d", i, bus.level, 15 - i); end
            end else begin
                checks++; if (bus.start_tx !== 1'b0 || bus.level !== 5'd0) begin failures++; $display("FAIL drain_end start=%0b level=%0d exp 0/0", bus.start_tx, bus.level); end
            end
            tick();
            checks++; if (bus.start_tx !== 1'b0) begin failures++; $display("FAIL drain_dup%0d got=%0b exp=0", i, bus.start_tx); end
        end
    endtask

    task automatic test_simul_and_wrap();
        logic [7:0] exp_q[$];
        int seen;
        do_reset();
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = 8'h40 + 8'(i);
            tick();
        end
        checks++; if (bus.level !== 5'd3) begin failures++; $display("FAIL simul_pre_level got=%0d exp=3", bus.level); end
        bus.wr_data = 8'h44;
        bus.tx_done = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        bus.tx_done = 1'b0;
        checks++; if (bus.level !== 5'd3 || bus.start_tx !== 1'b1 || bus.tx_data !== 8'h41) begin failures++; $display("FAIL simul level=%0d start=%0b data=%0h exp 3/1/41", bus.level, bus.start_tx, bus.tx_data); end

        do_reset();
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            exp_q.push_back(8'(k * 37 + 5));
            for (int ph = 0; ph < 3; ph++) begin
                bus.wr_valid = (ph == 0);
                bus.wr_data = 8'(k * 37 + 5);
                bus.tx_done = (ph == 1);
                tick();
                if (bus.start_tx === 1'b1) begin
                    seen++;
                    checks++;
                    if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_extra got=%0h exp=none", bus.tx_data); end
                    else if (bus.tx_data !== exp_q[0]) begin failures++; $display("FAIL wrap_byte%0d got=%0h exp=%0h", seen, bus.tx_data, exp_q[0]); void'(exp_q.pop_front()); end
                    else void'(exp_q.pop_front());
                end
            end
        end
        bus.wr_valid = 1'b0;
        bus.tx_done = 1'b0;
        checks++; if (seen != 40 || bus.level !== 5'd0) begin failures++; $display("FAIL wrap_count got=%0d level=%0d exp 40/0", seen, bus.level); end
        pulse_done();
    endtask

    task automatic test_flush();
        do_reset();
        write_byte(8'h33);
        tick();
        checks++; if (bus.start_tx !== 1'b1 || bus.tx_data !== 8'h33) begin failures++; $display("FAIL flush_inflight start=%0b data=%0h exp 1/33", bus.start_tx, bus.tx_data); end
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_data = 8'(i + 1);
            tick();
        end
        checks++; if (bus.overflow !== 1'b1 || bus.level !== 5'd16) begin failures++; $display("FAIL flush_pre ovf=%0b level=%0d exp 1/16", bus.overflow, bus.level); end
        bus.flush = 1'b1;
        bus.wr_data = 8'h77;
        #1;
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", bus.wr_ready); end
        tick();
        bus.flush = 1'b0;
        bus.wr_valid = 1'b0;
        checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin failures++; $display("FAIL flush_clear level=%0d empty=%0b ovf=%0b exp 0/1/0", bus.level, bus.empty, bus.overflow); end
        checks++; if (bus.start_tx !== 1'b0 || bus.tx_data !== 8'h33) begin failures++; $display("FAIL flush_keep start=%0b data=%0h exp 0/33", bus.start_tx, bus.tx_data); end
        pulse_done();
        tick();
        tick();
        checks++; if (bus.start_tx !== 1'b0 || bus.level !== 5'd0) begin failures++; $display("FAIL flush_after_done start=%0b level=%0d exp 0/0", bus.start_tx, bus.level); end
        write_byte(8'h55);
        tick();
        checks++; if (bus.start_tx !== 1'b1 || bus.tx_data !== 8'h55) begin failures++; $display("FAIL flush_idle_relaunch start=%0b data=%0h exp 1/55", bus.start_tx, bus.tx_data); end
        pulse_done();
    endtask

    task automatic test_done_ignored();
        do_reset();
        pulse_done();
        checks++; if (bus.start_tx !== 1'b0 || bus.level !== 5'd0) begin failures++; $display("FAIL idle_done start=%0b level=%0d exp 0/0", bus.start_tx, bus.level); end
        write_byte(8'h11);
        write_byte(8'h22);
        checks++; if (bus.start_tx !== 1'b1 || bus.tx_data !== 8'h11) begin failures++; $display("FAIL coinc_launch start=%0b data=%0h exp 1/11", bus.start_tx, bus.tx_data); end
        pulse_done();
        checks++; if (bus.start_tx !== 1'b0 || bus.tx_data !== 8'h11 || bus.level !== 5'd1) begin failures++; $display("FAIL coinc_done start=%0b data=%0h level=%0d exp 0/11/1", bus.start_tx, bus.tx_data, bus.level); end
        tick();
        tick();
        checks++; if (bus.start_tx !== 1'b0 || bus.level !== 5'd1) begin failures++; $display("FAIL coinc_wait start=%0b level=%0d exp 0/1", bus.start_tx, bus.level); end
        pulse_done();
        checks++; if (bus.start_tx !== 1'b1 || bus.tx_data !== 8'h22 || bus.level !== 5'd0) begin failures++; $display("FAIL coinc_next start=%0b data=%0h level=%0d exp 1/22/0", bus.start_tx, bus.tx_data, bus.level); end
        tick();
        pulse_done();
    endtask

`ifdef UART_TX_CTS_GATE_EN
    task automatic test_cts();
        int n;
        bit hit;
        do_reset();
        write_byte(8'hE1);
        write_byte(8'hE2);
        n = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.start_tx) n++; end
        checks++; if (n != 0 || bus.level !== 5'd2) begin failures++; $display("FAIL cts_block pulses=%0d level=%0d exp 0/2", n, bus.level); end
        bus.cts_n = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3 && !hit; i++) begin tick(); if (bus.start_tx) hit = 1'b1; end
        checks++; if (!hit || bus.tx_data !== 8'hE1) begin failures++; $display("FAIL cts_release hit=%0b data=%0h exp 1/e1", hit, bus.tx_data); end
        bus.cts_n = 1'b1;
        tick();
        tick();
        tick();
        pulse_done();
        n = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.start_tx) n++; end
        checks++; if (n != 0 || bus.level !== 5'd1) begin failures++; $display("FAIL cts_hold pulses=%0d level=%0d exp 0/1", n, bus.level); end
        bus.cts_n = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3 && !hit; i++) begin tick(); if (bus.start_tx) hit = 1'b1; end
        checks++; if (!hit || bus.tx_data !== 8'hE2) begin failures++; $display("FAIL cts_second hit=%0b data=%0h exp 1/e2", hit, bus.tx_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full_overflow();
        test_simul_and_wrap();
        test_flush();
        test_done_ignored();
`ifdef UART_TX_CTS_GATE_EN
        test_cts();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
